// File: rtl/cpu_pkg.sv
// Shared types and constants for the RISC-V core pipeline: widths, MEM-stage FSM
// encoding and the EX/MEM control bundle with its bubble value.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // A write to x0 is never reported, so forwarding from x0 cannot be selected.
  function automatic logic wr_qualify(input ctrl_t c, input logic [REG_AW-1:0] rd);
    return c.valid & c.reg_write & (rd != '0);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response handshake between the MEM stage (master) and
// the data memory (slave).
interface mem_wb_stage_if #(
  parameter int XLEN = cpu_pkg::XLEN
);

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ready;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );

endinterface

// File: rtl/wb_mux.sv
// Write-back value select: load data when MemtoReg is set, otherwise the ALU
// result carried through the MEM stage.
module wb_mux #(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic            mem_to_reg,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] wb_data
);

  assign wb_data = mem_to_reg ? rdata : alu_result;

endmodule

// File: rtl/mem_wb_stage.sv
// EX/MEM and MEM/WB pipeline registers, data-memory handshake, stall generation
// and forwarding sources. Optional access timeout enabled by MEM_TIMEOUT_EN.
module mem_wb_stage #(
  parameter int XLEN = cpu_pkg::XLEN
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_ex,
  input  logic [XLEN-1:0]            ALUResult_ex,
  input  logic [XLEN-1:0]            MemWriteData_ex,
  input  logic [cpu_pkg::REG_AW-1:0] rdAddr_ex,
  input  logic                       RegWrite_ex,
  input  logic                       MemRead_ex,
  input  logic                       MemWrite_ex,
  input  logic                       MemtoReg_ex,
  mem_wb_stage_if.master             dmem,
  output logic                       stall_mem,
  output logic [XLEN-1:0]            ALUResult_mem,
  output logic [cpu_pkg::REG_AW-1:0] rdAddr_mem,
  output logic                       RegWrite_mem,
  output logic [XLEN-1:0]            RegWriteData_wb,
  output logic [cpu_pkg::REG_AW-1:0] rdAddr_wb,
  output logic                       RegWrite_wb
`ifdef MEM_TIMEOUT_EN
  , output logic                     dmem_timeout
`endif
);

  import cpu_pkg::*;

  ctrl_t           ctrl_ex;
  ctrl_t           ctrl_mem;
  logic [XLEN-1:0] wdata_mem;
  logic [XLEN-1:0] wb_value;
  logic            mem_op;
  logic            timeout_hit;
  logic            wb_load;
  state_t          state;

  // NOTE: every variable driven from always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ctrl_ex = CTRL_BUBBLE;
    if (valid_ex) begin
      ctrl_ex.valid      = 1'b1;
      ctrl_ex.reg_write  = RegWrite_ex;
      ctrl_ex.mem_read   = MemRead_ex;
      ctrl_ex.mem_write  = MemWrite_ex;
      ctrl_ex.mem_to_reg = MemtoReg_ex;
    end
  end

  // Read+write together falls out as a store because dmem_we follows MemWrite alone.
  assign mem_op           = ctrl_mem.valid & (ctrl_mem.mem_read | ctrl_mem.mem_write);
  assign dmem.dmem_req    = mem_op;
  assign dmem.dmem_we     = ctrl_mem.mem_write;
  assign dmem.dmem_addr   = ALUResult_mem;
  assign dmem.dmem_wdata  = wdata_mem;
  assign RegWrite_mem     = wr_qualify(ctrl_mem, rdAddr_mem);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout_hit  = (state == WAIT) & ~dmem.dmem_ready
                      & (wait_cnt == 8'(TIMEOUT_CYCLES));
  assign dmem_timeout = timeout_hit;

  // Holds n during the n-th cycle spent in WAIT; zero whenever the FSM is in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (stall_mem) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  logic state_unused;

  assign timeout_hit  = 1'b0;
  // Without the timeout the FSM state has no consumer inside this block.
  assign state_unused = (state == WAIT);
`endif

  assign stall_mem = mem_op & ~dmem.dmem_ready & ~timeout_hit;
  assign wb_load   = ~stall_mem & ~timeout_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (mem_op & ~dmem.dmem_ready) state <= WAIT;
        WAIT:    if (dmem.dmem_ready | timeout_hit) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_mem      <= CTRL_BUBBLE;
      ALUResult_mem <= '0;
      wdata_mem     <= '0;
      rdAddr_mem    <= '0;
    end else if (!stall_mem) begin
      ctrl_mem      <= ctrl_ex;
      ALUResult_mem <= ALUResult_ex;
      wdata_mem     <= MemWriteData_ex;
      rdAddr_mem    <= rdAddr_ex;
    end
  end

  wb_mux #(.XLEN(XLEN)) u_wb_mux (
    .mem_to_reg (ctrl_mem.mem_to_reg),
    .rdata      (dmem.dmem_rdata),
    .alu_result (ALUResult_mem),
    .wb_data    (wb_value)
  );

  // A stalled or abandoned access sends a bubble so the register file is never written twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteData_wb <= '0;
      rdAddr_wb       <= '0;
      RegWrite_wb     <= 1'b0;
    end else if (wb_load) begin
      RegWriteData_wb <= wb_value;
      rdAddr_wb       <= rdAddr_mem;
      RegWrite_wb     <= RegWrite_mem;
    end else begin
      RegWrite_wb     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, multi-cycle corner
// sequences and a randomized run against a transaction-level pipeline model.
module tb_mem_wb_stage;

  localparam int W = 32;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
  } instr_t;

  typedef struct packed {
    instr_t      in;
    logic [31:0] rdata;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic        exp_rwm;
    logic [31:0] exp_wb;
    logic        exp_rwb;
  } vec_t;

  localparam instr_t BUBBLE = '0;
  localparam int     NV     = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_ex;
  logic [W-1:0]  ALUResult_ex;
  logic [W-1:0]  MemWriteData_ex;
  logic [4:0]    rdAddr_ex;
  logic          RegWrite_ex;
  logic          MemRead_ex;
  logic          MemWrite_ex;
  logic          MemtoReg_ex;
  logic          stall_mem;
  logic [W-1:0]  ALUResult_mem;
  logic [4:0]    rdAddr_mem;
  logic          RegWrite_mem;
  logic [W-1:0]  RegWriteData_wb;
  logic [4:0]    rdAddr_wb;
  logic          RegWrite_wb;
`ifdef MEM_TIMEOUT_EN
  logic          dmem_timeout;
`endif

  int checks = 0;
  int errors = 0;

  mem_wb_stage_if #(.XLEN(W)) dmem ();

  mem_wb_stage #(
    .XLEN(W)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_ex        (valid_ex),
    .ALUResult_ex    (ALUResult_ex),
    .MemWriteData_ex (MemWriteData_ex),
    .rdAddr_ex       (rdAddr_ex),
    .RegWrite_ex     (RegWrite_ex),
    .MemRead_ex      (MemRead_ex),
    .MemWrite_ex     (MemWrite_ex),
    .MemtoReg_ex     (MemtoReg_ex),
    .dmem            (dmem),
    .stall_mem       (stall_mem),
    .ALUResult_mem   (ALUResult_mem),
    .rdAddr_mem      (rdAddr_mem),
    .RegWrite_mem    (RegWrite_mem),
    .RegWriteData_wb (RegWriteData_wb),
    .rdAddr_wb       (rdAddr_wb),
    .RegWrite_wb     (RegWrite_wb)
`ifdef MEM_TIMEOUT_EN
    , .dmem_timeout  (dmem_timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_t i);
    valid_ex        = i.valid;
    ALUResult_ex    = i.alu;
    MemWriteData_ex = i.wd;
    rdAddr_ex       = i.rd;
    RegWrite_ex     = i.rw;
    MemRead_ex      = i.mr;
    MemWrite_ex     = i.mw;
    MemtoReg_ex     = i.m2r;
  endtask

  function automatic instr_t ins(input logic v, input logic [31:0] a, input logic [31:0] w,
                                 input logic [4:0] r, input logic rw, input logic mr,
                                 input logic mw, input logic m2r);
    instr_t i;
    i = '{valid: v, alu: a, wd: w, rd: r, rw: rw, mr: mr, mw: mw, m2r: m2r};
    return i;
  endfunction

  vec_t vt [NV];

  // Transaction-level model state for the random phase.
  instr_t      m_mem;
  logic [31:0] m_wb_data;
  logic [4:0]  m_wb_rd;
  logic        m_wb_rw;
  int          m_stall_run;

  initial begin
    instr_t      ex;
    logic        e_req;
    logic        e_stall;
    int          stall_cnt;
    int          done_cnt;

    // in, rdata, req, we, wdata, RegWrite_mem, RegWriteData_wb, RegWrite_wb
    vt[0] = '{ins(1'b1, 32'h55, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), 32'h0,
              1'b0, 1'b0, 32'h0, 1'b1, 32'h55, 1'b1};
    vt[1] = '{ins(1'b1, 32'h77, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), 32'h0,
              1'b0, 1'b0, 32'h0, 1'b0, 32'h77, 1'b0};
    vt[2] = '{ins(1'b1, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1), 32'hDEAD_BEEF,
              1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1};
    vt[3] = '{ins(1'b1, 32'h200, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), 32'h0,
              1'b1, 1'b1, 32'h1234, 1'b0, 32'h200, 1'b0};
    vt[4] = '{ins(1'b0, 32'h300, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0), 32'h0,
              1'b0, 1'b0, 32'h0, 1'b0, 32'h300, 1'b0};
    vt[5] = '{ins(1'b1, 32'h44, 32'hAA, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0), 32'h5555,
              1'b1, 1'b1, 32'hAA, 1'b0, 32'h44, 1'b0};
    vt[6] = '{ins(1'b1, 32'h10, 32'h0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1), 32'h0BAD_F00D,
              1'b1, 1'b0, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b1};

    reset = 1'b1;
    drive(BUBBLE);
    dmem.dmem_ready = 1'b1;
    dmem.dmem_rdata = '0;
    #2;
    check("rst_req",      32'(dmem.dmem_req), 32'd0);
    check("rst_we",       32'(dmem.dmem_we), 32'd0);
    check("rst_addr",     dmem.dmem_addr, 32'd0);
    check("rst_wdata",    dmem.dmem_wdata, 32'd0);
    check("rst_stall",    32'(stall_mem), 32'd0);
    check("rst_rd_mem",   32'(rdAddr_mem), 32'd0);
    check("rst_rw_mem",   32'(RegWrite_mem), 32'd0);
    check("rst_wb_data",  RegWriteData_wb, 32'd0);
    check("rst_rd_wb",    32'(rdAddr_wb), 32'd0);
    check("rst_rw_wb",    32'(RegWrite_wb), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed zero-wait vectors: one instruction followed by bubbles.
    for (int k = 0; k < NV; k++) begin
      tick();
      drive(vt[k].in);
      dmem.dmem_ready = 1'b1;
      dmem.dmem_rdata = vt[k].rdata;
      tick();
      drive(BUBBLE);
      #1;
      check($sformatf("v%0d_req", k),    32'(dmem.dmem_req), 32'(vt[k].exp_req));
      check($sformatf("v%0d_we", k),     32'(dmem.dmem_we), 32'(vt[k].exp_we));
      check($sformatf("v%0d_addr", k),   dmem.dmem_addr, vt[k].in.alu);
      check($sformatf("v%0d_alu_mem", k), ALUResult_mem, vt[k].in.alu);
      if (vt[k].exp_we) check($sformatf("v%0d_wdata", k), dmem.dmem_wdata, vt[k].exp_wdata);
      check($sformatf("v%0d_stall", k),  32'(stall_mem), 32'd0);
      check($sformatf("v%0d_rd_mem", k), 32'(rdAddr_mem), 32'(vt[k].in.rd));
      check($sformatf("v%0d_rw_mem", k), 32'(RegWrite_mem), 32'(vt[k].exp_rwm));
      tick();
      #1;
      check($sformatf("v%0d_wb_data", k), RegWriteData_wb, vt[k].exp_wb);
      check($sformatf("v%0d_rd_wb", k),   32'(rdAddr_wb), 32'(vt[k].in.rd));
      check($sformatf("v%0d_rw_wb", k),   32'(RegWrite_wb), 32'(vt[k].exp_rwb));
    end

    // Store with three wait cycles; the following ALU op waits in EX.
    tick();
    drive(ins(1'b1, 32'h80, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    dmem.dmem_ready = 1'b1;
    tick();
    drive(ins(1'b1, 32'h999, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0));
    stall_cnt = 0;
    done_cnt  = 0;
    for (int c = 0; c < 5; c++) begin
      dmem.dmem_ready = (c >= 3);
      if (c == 4) drive(BUBBLE);
      #1;
      if (stall_mem) stall_cnt++;
      if (dmem.dmem_req && dmem.dmem_ready) done_cnt++;
      if (c <= 3) begin
        check($sformatf("st%0d_we", c),    32'(dmem.dmem_we), 32'd1);
        check($sformatf("st%0d_addr", c),  dmem.dmem_addr, 32'h80);
        check($sformatf("st%0d_wdata", c), dmem.dmem_wdata, 32'h1234);
        check($sformatf("st%0d_rw_wb", c), 32'(RegWrite_wb), 32'd0);
      end else begin
        check("st_next_alu_mem", ALUResult_mem, 32'h999);
        check("st_next_rw_mem",  32'(RegWrite_mem), 32'd1);
        check("st_next_req",     32'(dmem.dmem_req), 32'd0);
      end
      tick();
    end
    check("st_stall_cycles", 32'(stall_cnt), 32'd3);
    check("st_completions",  32'(done_cnt), 32'd1);

    // Reset asserted in the second cycle of a stalled load.
    drive(ins(1'b1, 32'h140, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1));
    dmem.dmem_ready = 1'b0;
    tick();
    drive(BUBBLE);
    #1;
    check("rw_c1_stall", 32'(stall_mem), 32'd1);
    tick();
    #1;
    check("rw_c2_stall",  32'(stall_mem), 32'd1);
    check("rw_c2_rw_mem", 32'(RegWrite_mem), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("rw_async_req",    32'(dmem.dmem_req), 32'd0);
    check("rw_async_stall",  32'(stall_mem), 32'd0);
    check("rw_async_rw_mem", 32'(RegWrite_mem), 32'd0);
    check("rw_async_rw_wb",  32'(RegWrite_wb), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    dmem.dmem_ready = 1'b1;
    tick();
    drive(ins(1'b1, 32'h55, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    drive(BUBBLE);
    #1;
    check("rw_after_alu_mem", ALUResult_mem, 32'h55);
    check("rw_after_rd_mem",  32'(rdAddr_mem), 32'd5);
    check("rw_after_rw_mem",  32'(RegWrite_mem), 32'd1);
    tick();
    #1;
    check("rw_after_wb_data", RegWriteData_wb, 32'h55);
    check("rw_after_rw_wb",   32'(RegWrite_wb), 32'd1);

`ifdef MEM_TIMEOUT_EN
    // Memory never answers: the 4th WAIT cycle force-completes the access.
    drive(ins(1'b1, 32'h180, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1));
    dmem.dmem_ready = 1'b0;
    tick();
    drive(BUBBLE);
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("to%0d_timeout", k), 32'(dmem_timeout), 32'(k == 4));
      check($sformatf("to%0d_stall", k),   32'(stall_mem), 32'(k < 4));
      if (k == 5) begin
        check("to_after_req",   32'(dmem.dmem_req), 32'd0);
        check("to_after_rw_wb", 32'(RegWrite_wb), 32'd0);
      end
      tick();
    end
    dmem.dmem_ready = 1'b1;
`endif

    // Randomized run against the transaction-level model.
    @(negedge clk);
    reset = 1'b1;
    drive(BUBBLE);
    @(negedge clk);
    reset = 1'b0;
    m_mem       = BUBBLE;
    m_wb_data   = '0;
    m_wb_rd     = '0;
    m_wb_rw     = 1'b0;
    m_stall_run = 0;
    for (int n = 0; n < 300; n++) begin
      int op;
      tick();
      op        = int'($urandom_range(0, 3));
      ex.valid  = ($urandom_range(0, 3) != 0);
      ex.alu    = $urandom;
      ex.wd     = $urandom;
      ex.rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      ex.rw     = 1'($urandom_range(0, 1));
      ex.mr     = (op == 1) || (op == 3);
      ex.mw     = (op == 2) || (op == 3);
      ex.m2r    = ex.valid & ex.mr & ~ex.mw;
      drive(ex);
      dmem.dmem_ready = (m_stall_run >= 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
      dmem.dmem_rdata = $urandom;
      #1;
      e_req   = m_mem.valid & (m_mem.mr | m_mem.mw);
      e_stall = e_req & ~dmem.dmem_ready;
      check("rnd_req",     32'(dmem.dmem_req), 32'(e_req));
      check("rnd_we",      32'(dmem.dmem_we), 32'(m_mem.valid & m_mem.mw));
      check("rnd_addr",    dmem.dmem_addr, m_mem.alu);
      check("rnd_wdata",   dmem.dmem_wdata, m_mem.wd);
      check("rnd_stall",   32'(stall_mem), 32'(e_stall));
      check("rnd_rd_mem",  32'(rdAddr_mem), 32'(m_mem.rd));
      check("rnd_rw_mem",  32'(RegWrite_mem), 32'(m_mem.valid & m_mem.rw & (m_mem.rd != 5'd0)));
      check("rnd_wb_data", RegWriteData_wb, m_wb_data);
      check("rnd_rd_wb",   32'(rdAddr_wb), 32'(m_wb_rd));
      check("rnd_rw_wb",   32'(RegWrite_wb), 32'(m_wb_rw));
      if (e_stall) begin
        m_wb_rw = 1'b0;
        m_stall_run++;
      end else begin
        m_wb_data   = (m_mem.valid & m_mem.m2r) ? dmem.dmem_rdata : m_mem.alu;
        m_wb_rd     = m_mem.rd;
        m_wb_rw     = m_mem.valid & m_mem.rw & (m_mem.rd != 5'd0);
        m_mem       = ex;
        m_stall_run = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
